// File: rtl/fb_double_buffer.sv
// fb_double_buffer
//   Two-bank pixel store between the renderer and the VGA output stage.
//   The renderer writes the back bank (x/y/color). The display timing reads
//   the front bank through a registered 2-cycle pipeline. A swap request is
//   latched and performed on the next frame_start, so a frame never mixes
//   banks. A clear engine fills the back bank with CLEAR_COLOR, one word per
//   cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   we, x, y, color     back-bank write (accepted only while wr_ready=1)
//   wr_ready            back bank accepts writes (no clear running)
//   clear_req           pulse: fill the back bank with CLEAR_COLOR
//   swap_req            pulse: exchange banks at the next frame_start
//   swap_pending        swap requested but not yet performed
//   front_sel           index of the bank being displayed
//   frame_start         pulse from display timing at start of vblank
//   oe, sx, sy          display active-video enable and screen position
//   r, g, b             pixel colour, 0 outside the buffer window
module fb_double_buffer #(
    parameter int unsigned XY_BITW = 16,
    parameter int unsigned WIDTH   = 100,
    parameter int unsigned HEIGHT  = 100,
    parameter int unsigned CHW     = 1,
    parameter int unsigned POSX    = 250,
    parameter int unsigned POSY    = 250,
    parameter logic [3*CHW-1:0] CLEAR_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [XY_BITW-1:0] x,
    input  logic [XY_BITW-1:0] y,
    input  logic [3*CHW-1:0]   color,
    output logic               wr_ready,
    input  logic               clear_req,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               front_sel,
    input  logic               frame_start,
    input  logic               oe,
    input  logic [XY_BITW-1:0] sx,
    input  logic [XY_BITW-1:0] sy,
    output logic [CHW-1:0]     r,
    output logic [CHW-1:0]     g,
    output logic [CHW-1:0]     b
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned PW    = 3 * CHW;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          clearing;
    logic [AW-1:0] clr_cnt;

    logic [PW-1:0] mem [2][DEPTH];

    logic          wr_ok;
    logic [AW-1:0] wr_addr;
    logic          back_sel;
    logic          do_swap;

    logic          in_win;
    logic [AW-1:0] rd_lin;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic          win0;
    logic          win1;
    logic [PW-1:0] rd_data;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_req) state_d = CLEAR;
            CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        clearing = 1'b0;
        case (state_q)
            IDLE:    wr_ready = 1'b1;
            CLEAR:   clearing = 1'b1;
            default: wr_ready = 1'b1;
        endcase
    end

    // Held at zero while idle so every clear starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           clr_cnt <= '0;
        else if (clearing) clr_cnt <= clr_cnt + 1'b1;
        else               clr_cnt <= '0;
    end

    // ---------------- swap control ----------------
    assign do_swap  = frame_start && swap_pending && (state_q == IDLE);
    assign back_sel = ~front_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (do_swap) begin
            front_sel    <= ~front_sel;
            // A request arriving with the swap itself queues one more swap.
            swap_pending <= swap_req;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // ---------------- write path ----------------
    assign wr_ok   = we && wr_ready
                     && (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign wr_addr = AW'(32'(y) * WIDTH + 32'(x));

    // ---------------- read address stage ----------------
    assign in_win = oe
                    && (32'(sx) >= POSX) && (32'(sx) <= POSX + WIDTH - 1)
                    && (32'(sy) >= POSY) && (32'(sy) <= POSY + HEIGHT - 1);
    assign rd_lin = AW'((32'(sy) - POSY) * WIDTH + (32'(sx) - POSX));

    // The bank is captured with the address so a read in flight across a
    // swap still completes from the bank it started on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
            rd_bank <= 1'b0;
            win0    <= 1'b0;
            win1    <= 1'b0;
        end else begin
            rd_addr <= rd_lin;
            rd_bank <= front_sel;
            win0    <= in_win;
            win1    <= win0;
        end
    end

    // ---------------- storage (not touched by rst) ----------------
    always_ff @(posedge clk) begin
        if (clearing)   mem[back_sel][clr_cnt] <= CLEAR_COLOR;
        else if (wr_ok) mem[back_sel][wr_addr] <= color;
        rd_data <= mem[rd_bank][rd_addr];
    end

    assign {r, g, b} = win1 ? rd_data : '0;

endmodule

// File: tb/tb_fb_double_buffer.sv
module tb_fb_double_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, clear_req = 1'b0, swap_req = 1'b0;
    logic        frame_start = 1'b0, oe = 1'b0;
    logic [15:0] x = '0, y = '0, sx = '0, sy = '0;
    logic [5:0]  color = '0;
    logic        wr_ready, swap_pending, front_sel;
    logic [1:0]  r, g, b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bank contents and front index, updated from the
    // documented rules of each operation.
    logic [5:0] mem_m [2][16];
    bit         front_m = 1'b0;
    bit         clr_m = 1'b0;
    int         q_oe[$], q_sx[$], q_sy[$];

    fb_double_buffer #(
        .XY_BITW(16), .WIDTH(4), .HEIGHT(4), .CHW(2),
        .POSX(10), .POSY(20), .CLEAR_COLOR(6'h3F)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .x(x), .y(y), .color(color),
        .wr_ready(wr_ready), .clear_req(clear_req), .swap_req(swap_req),
        .swap_pending(swap_pending), .front_sel(front_sel),
        .frame_start(frame_start), .oe(oe), .sx(sx), .sy(sy),
        .r(r), .g(g), .b(b)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [5:0] exp_pix(input int o, input int px, input int py);
        if (o != 0 && px >= 10 && px <= 13 && py >= 20 && py <= 23)
            return mem_m[front_m][(py - 20) * 4 + (px - 10)];
        return 6'h00;
    endfunction

    function automatic int back_idx();
        return front_m ? 0 : 1;
    endfunction

    task automatic write_px(input int px, input int py, input logic [5:0] c);
        @(negedge clk);
        we = 1'b1; x = 16'(px); y = 16'(py); color = c;
        @(negedge clk);
        we = 1'b0;
        if (!clr_m && px < 4 && py < 4) mem_m[back_idx()][py * 4 + px] = c;
    endtask

    task automatic fill_back();
        for (int a = 0; a < 16; a++) write_px(a % 4, a / 4, 6'($urandom_range(1, 62)));
    endtask

    task automatic push_all();
        for (int a = 0; a < 16; a++) begin
            q_oe.push_back(1); q_sx.push_back(10 + a % 4); q_sy.push_back(20 + a / 4);
        end
    endtask

    // Streams the queued positions one per cycle; each result is checked
    // exactly two cycles after its position was applied.
    task automatic run_scan(input string name);
        int n;
        logic [5:0] expq[$];
        logic [5:0] e;
        n = q_sx.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                e = expq.pop_front();
                vectors++;
                if ({r, g, b} !== e) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: rgb=%h expected %h", name, k - 2, {r, g, b}, e);
                end
            end
            if (k < n) begin
                oe = (q_oe[k] != 0); sx = 16'(q_sx[k]); sy = 16'(q_sy[k]);
                expq.push_back(exp_pix(q_oe[k], q_sx[k], q_sy[k]));
            end else begin
                oe = 1'b0;
            end
        end
        q_oe.delete(); q_sx.delete(); q_sy.delete();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_ready) break;
        end
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_timeout: wr_ready=%b expected 1", wr_ready);
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clear_req = 1'b1; clr_m = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        wait_ready();
        for (int a = 0; a < 16; a++) mem_m[back_idx()][a] = 6'h3F;
        clr_m = 1'b0;
    endtask

    task automatic do_swap();
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        front_m = ~front_m;
        vectors++;
        if (front_sel !== front_m || swap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL swap: front_sel=%b pending=%b expected %b/0", front_sel, swap_pending, front_m);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (wr_ready !== 1'b1 || front_sel !== 1'b0 || swap_pending !== 1'b0 || {r, g, b} !== 6'h00) begin
            miscompares++;
            $display("FAIL reset: ready=%b front=%b pend=%b rgb=%h expected 1/0/0/00",
                     wr_ready, front_sel, swap_pending, {r, g, b});
        end
        @(negedge clk); rst = 1'b0;
        // Bring both banks to a known state through the clear engine.
        do_clear(); do_swap(); do_clear();
    endtask

    task automatic test_basic();
        write_px(1, 2, 6'h2D);
        q_oe.push_back(1); q_sx.push_back(11); q_sy.push_back(22);
        run_scan("pre_swap");
        do_swap();
        q_oe.push_back(1); q_sx.push_back(11); q_sy.push_back(22);
        run_scan("post_swap");
        @(negedge clk); oe = 1'b1; sx = 16'd11; sy = 16'd22;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (r !== 2'b10 || g !== 2'b11 || b !== 2'b01) begin
            miscompares++;
            $display("FAIL channels: r=%b g=%b b=%b expected 10/11/01", r, g, b);
        end
        oe = 1'b0;
    endtask

    task automatic test_window();
        int e_oe[7] = '{1, 1, 1, 1, 1, 0, 1};
        int e_sx[7] = '{9, 14, 11, 11, 13, 11, 10};
        int e_sy[7] = '{22, 22, 19, 24, 23, 22, 20};
        for (int i = 0; i < 7; i++) begin
            q_oe.push_back(e_oe[i]); q_sx.push_back(e_sx[i]); q_sy.push_back(e_sy[i]);
        end
        for (int i = 0; i < 16; i++) begin
            q_oe.push_back(int'($urandom_range(0, 3) != 0));
            q_sx.push_back(int'($urandom_range(8, 15)));
            q_sy.push_back(int'($urandom_range(18, 25)));
        end
        run_scan("window");
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 6; i++)
            write_px(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 6'($urandom_range(1, 62)));
        write_px(4, 0, 6'($urandom_range(1, 62)));
        write_px(0, 4, 6'($urandom_range(1, 62)));
        write_px(7, 9, 6'($urandom_range(1, 62)));
        do_swap();
        push_all();
        run_scan("oor");
    endtask

    task automatic test_clear();
        int n = 0;
        fill_back();
        @(negedge clk); clear_req = 1'b1; clr_m = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready) break;
            n++;
            we = (n <= 10);
            x = 16'($urandom_range(0, 3)); y = 16'($urandom_range(0, 3));
            color = 6'($urandom_range(0, 62));
            clear_req = (n == 5);
            @(negedge clk);
        end
        we = 1'b0; clear_req = 1'b0;
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL clear_len: wr_ready low %0d cycles expected 16", n);
        end
        for (int a = 0; a < 16; a++) mem_m[back_idx()][a] = 6'h3F;
        clr_m = 1'b0;
        do_swap();
        push_all();
        run_scan("cleared");
    endtask

    task automatic test_swap_defer();
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0;
        vectors++;
        if (swap_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_set: pending=%b expected 1", swap_pending);
        end
        clear_req = 1'b1; clr_m = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        vectors++;
        if (front_sel !== front_m || swap_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL defer: front=%b pend=%b expected %b/1", front_sel, swap_pending, front_m);
        end
        wait_ready();
        for (int a = 0; a < 16; a++) mem_m[back_idx()][a] = 6'h3F;
        clr_m = 1'b0;
        frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        front_m = ~front_m;
        vectors++;
        if (front_sel !== front_m || swap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL deferred_swap: front=%b pend=%b expected %b/0", front_sel, swap_pending, front_m);
        end
        // Request coinciding with a swap stays pending for one more swap.
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); swap_req = 1'b0; frame_start = 1'b0;
        front_m = ~front_m;
        vectors++;
        if (front_sel !== front_m || swap_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle: front=%b pend=%b expected %b/1", front_sel, swap_pending, front_m);
        end
        // Repeated requests while pending give one swap only.
        swap_req = 1'b1;
        @(negedge clk);
        @(negedge clk); swap_req = 1'b0; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        front_m = ~front_m;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        vectors++;
        if (front_sel !== front_m || swap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL repeat_req: front=%b pend=%b expected %b/0", front_sel, swap_pending, front_m);
        end
        push_all();
        run_scan("after_defer");
    endtask

    task automatic test_rst_mid_clear();
        int bk;
        fill_back();
        @(negedge clk); swap_req = 1'b1;
        @(negedge clk); swap_req = 1'b0; oe = 1'b1; sx = 16'd10; sy = 16'd20;
        @(negedge clk); clear_req = 1'b1; clr_m = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        vectors++;
        if ({r, g, b} !== mem_m[front_m][0]) begin
            miscompares++;
            $display("FAIL pre_rst_rgb: rgb=%h expected %h", {r, g, b}, mem_m[front_m][0]);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (wr_ready !== 1'b1 || front_sel !== 1'b0 || swap_pending !== 1'b0 || {r, g, b} !== 6'h00) begin
            miscompares++;
            $display("FAIL rst_mid_clear: ready=%b front=%b pend=%b rgb=%h expected 1/0/0/00",
                     wr_ready, front_sel, swap_pending, {r, g, b});
        end
        bk = back_idx();
        for (int a = 0; a < 5; a++) mem_m[bk][a] = 6'h3F;
        front_m = 1'b0; clr_m = 1'b0;
        @(negedge clk); rst = 1'b0; oe = 1'b0;
        push_all();
        run_scan("rst_front");
        do_swap();
        push_all();
        run_scan("rst_other");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_window();
        test_out_of_range();
        test_clear();
        test_swap_defer();
        test_rst_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
